// File: rtl/core_run_ctrl_if.sv
// Program-load stream and IMem write port between the host/debug side and core_run_ctrl.
// The master is the host plus IMem; the slave is the run sequencer.
interface core_run_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run sequencer for the single-cycle core: loads IMem over a valid/ready stream,
// releases the core, and stops it on request, on ebreak, or at a cycle limit.
module core_run_ctrl #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int          CYCLE_W    = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               run_start,
  input  logic               halt_req,
  input  logic               clear,
  input  logic [CYCLE_W-1:0] cycle_limit,
  core_run_ctrl_if.slave     ld,
  input  logic [31:0]        core_instr,
  output logic               core_reset,
  output logic               core_enable,
  output logic [1:0]         state,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [ADDR_W:0]    words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  state_t             state_q;
  logic [ADDR_W-1:0]  load_addr;
  logic [CYCLE_W-1:0] limit_q;
  logic               xfer;
  logic [1:0]         stop_cause;
  logic               stop;

  assign state = state_q;

  // Stop decode is combinational so the stopping instruction never gets an enabled cycle.
  always_comb begin
    stop_cause = 2'd0;
    if (state_q == S_RUN) begin
      if (halt_req)
        stop_cause = 2'd1;
      else if (core_instr == HALT_INSTR)
        stop_cause = 2'd2;
      else if ((limit_q != '0) && (cycle_count == limit_q))
        stop_cause = 2'd3;
    end
  end

  assign stop        = (stop_cause != 2'd0);
  assign core_reset  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign core_enable = (state_q == S_RUN) && !stop;

  assign ld.load_ready = (state_q == S_LOAD);
  assign xfer          = ld.load_valid && (state_q == S_LOAD);
  assign ld.imem_we    = xfer;
  assign ld.imem_waddr = xfer ? load_addr : '0;
  assign ld.imem_wdata = xfer ? ld.load_data : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      load_addr    <= '0;
      limit_q      <= '0;
      halt_cause   <= 2'd0;
      cycle_count  <= '0;
      words_loaded <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q      <= S_LOAD;
            load_addr    <= '0;
            words_loaded <= '0;
          end else if (run_start) begin
            state_q     <= S_RUN;
            limit_q     <= cycle_limit;
            cycle_count <= '0;
            halt_cause  <= 2'd0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            load_addr    <= load_addr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            // The last IMem slot ends the load even without load_last; there is no wrap.
            if (ld.load_last || (load_addr == LAST_ADDR))
              state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q    <= S_HALT;
            halt_cause <= stop_cause;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CYCLE_W'(1);
          end
        end
        S_HALT: begin
          if (clear)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: randomized loads and runs checked against
// a transaction-level model (expected writes list, computed stop index and cause).
module tb_core_run_ctrl;

  localparam int          IMEM_DEPTH = 256;
  localparam int          ADDR_W     = 8;
  localparam int          CYCLE_W    = 32;
  localparam logic [31:0] HALT_INSTR = 32'h00100073;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start, run_start, halt_req, clear;
  logic [CYCLE_W-1:0] cycle_limit;
  logic [31:0]        core_instr;
  logic               core_reset, core_enable;
  logic [1:0]         state, halt_cause;
  logic [CYCLE_W-1:0] cycle_count;
  logic [ADDR_W:0]    words_loaded;

  int vectorCount = 0;
  int missCount   = 0;

  core_run_ctrl_if #(.ADDR_W(ADDR_W)) ld_if ();

  core_run_ctrl #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .ADDR_W    (ADDR_W),
    .CYCLE_W   (CYCLE_W),
    .HALT_INSTR(HALT_INSTR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .run_start   (run_start),
    .halt_req    (halt_req),
    .clear       (clear),
    .cycle_limit (cycle_limit),
    .ld          (ld_if),
    .core_instr  (core_instr),
    .core_reset  (core_reset),
    .core_enable (core_enable),
    .state       (state),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
    .words_loaded(words_loaded)
  );

  // Free-running clock; inputs change 1ns after posedge, outputs are sampled at negedge.
  always #5 clk = ~clk;

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the command lines for this cycle and move to the sampling point.
  task automatic applyStimulus(input logic ls, input logic rs, input logic hr, input logic cl);
    load_start = ls;
    run_start  = rs;
    halt_req   = hr;
    clear      = cl;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nonHaltWord();
    logic [31:0] r;
    r = $urandom;
    while (r == HALT_INSTR) r = $urandom;
    return r;
  endfunction

  // Load n words (last flagged on word n-1 when useLast); gapIdx forces one idle cycle
  // before that word, abortAfter stops driving once that many words went in.
  task automatic doLoad(input int n, input bit useLast, input int gapPct, input int gapIdx,
                        input int abortAfter, output int accepted);
    logic [31:0] words[$];
    int          total;
    int          budget;
    bit          gapDone;
    logic        v;
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
    total = IMEM_DEPTH;
    if (useLast && n < IMEM_DEPTH) total = n;

    ld_if.load_valid = 1'b0;
    applyStimulus(1'b1, 1'($urandom % 2), 1'b0, 1'b0);
    checkOutput("idle_core_reset", core_reset, 1);
    nextCycle();

    accepted = 0;
    budget   = 0;
    gapDone  = 0;
    while (accepted < total && budget < 4000) begin
      if (abortAfter >= 0 && accepted == abortAfter) break;
      v = ($urandom_range(99) >= gapPct);
      if (accepted == gapIdx && !gapDone) begin
        v       = 1'b0;
        gapDone = 1;
      end
      ld_if.load_valid = v;
      ld_if.load_data  = words[accepted];
      ld_if.load_last  = v ? (useLast && accepted == n - 1) : 1'($urandom % 2);
      core_instr       = $urandom;
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      checkOutput("load_state", state, 1);
      checkOutput("load_ready", ld_if.load_ready, 1);
      checkOutput("load_core_reset", core_reset, 1);
      checkOutput("load_core_enable", core_enable, 0);
      checkOutput("imem_we", ld_if.imem_we, v);
      checkOutput("imem_waddr", ld_if.imem_waddr, v ? accepted : 0);
      checkOutput("imem_wdata", ld_if.imem_wdata, v ? words[accepted] : 32'h0);
      if (v) accepted++;
      nextCycle();
      budget++;
    end
    if (budget >= 4000) checkOutput("load_timeout", 0, 1);

    if (abortAfter < 0) begin
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = $urandom;
      ld_if.load_last  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("load_done_state", state, 0);
      checkOutput("load_done_we", ld_if.imem_we, 0);
      checkOutput("load_done_ready", ld_if.load_ready, 0);
      checkOutput("load_done_waddr", ld_if.imem_waddr, 0);
      checkOutput("words_loaded", words_loaded, total);
      ld_if.load_valid = 1'b0;
      nextCycle();
    end
  endtask

  // Run with a given limit and stop stimulus; the model is the first cycle index
  // at which a stop rule fires, with the cause from the priority order.
  task automatic doRun(input int limit, input int ebreakAt, input int haltReqAt, input int budget);
    int k;
    int cause;
    k     = -1;
    cause = 0;
    for (int i = 0; i <= budget && k < 0; i++) begin
      if (i == haltReqAt)                 begin k = i; cause = 1; end
      else if (i == ebreakAt)             begin k = i; cause = 2; end
      else if (limit != 0 && i == limit)  begin k = i; cause = 3; end
    end
    if (k < 0) begin
      checkOutput("run_config", 0, 1);
      return;
    end

    cycle_limit = CYCLE_W'(limit);
    core_instr  = nonHaltWord();
    applyStimulus(1'b0, 1'b1, 1'($urandom % 2), 1'($urandom % 2));
    checkOutput("pre_run_state", state, 0);
    nextCycle();

    for (int i = 0; i <= k; i++) begin
      cycle_limit = $urandom;
      core_instr  = (i == ebreakAt) ? HALT_INSTR : nonHaltWord();
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'(i == haltReqAt), 1'($urandom % 2));
      checkOutput("run_state", state, 2);
      checkOutput("run_core_reset", core_reset, 0);
      checkOutput("run_core_enable", core_enable, i != k);
      checkOutput("run_cycle_count", cycle_count, i);
      checkOutput("run_halt_cause", halt_cause, 0);
      nextCycle();
    end

    for (int j = 0; j < 3; j++) begin
      core_instr = $urandom;
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b0);
      checkOutput("halt_state", state, 3);
      checkOutput("halt_core_enable", core_enable, 0);
      checkOutput("halt_core_reset", core_reset, 0);
      checkOutput("halt_cause", halt_cause, cause);
      checkOutput("halt_cycle_count", cycle_count, k);
      nextCycle();
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_state", state, 3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cleared_state", state, 0);
    checkOutput("cleared_core_reset", core_reset, 1);
    checkOutput("cleared_halt_cause", halt_cause, cause);
    checkOutput("cleared_cycle_count", cycle_count, k);
    nextCycle();
  endtask

  initial begin
    int acc;
    int lim, eb, hr;

    reset            = 1'b1;
    load_start       = 1'b0;
    run_start        = 1'b0;
    halt_req         = 1'b0;
    clear            = 1'b0;
    cycle_limit      = '0;
    core_instr       = 32'h0;
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = 32'h0;
    ld_if.load_last  = 1'b0;

    nextCycle();
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_core_enable", core_enable, 0);
    checkOutput("rst_load_ready", ld_if.load_ready, 0);
    checkOutput("rst_imem_we", ld_if.imem_we, 0);
    checkOutput("rst_halt_cause", halt_cause, 0);
    checkOutput("rst_cycle_count", cycle_count, 0);
    checkOutput("rst_words_loaded", words_loaded, 0);
    nextCycle();

    doLoad(4, 1'b1, 0, 2, -1, acc);
    doLoad(int'($urandom_range(1, 20)), 1'b1, 30, -1, -1, acc);
    doLoad(300, 1'b0, 20, -1, -1, acc);

    doRun(0, 5, -1, 20);
    doRun(10, -1, -1, 20);
    doRun(0, 3, 3, 20);
    doRun(1, -1, -1, 5);
    doRun(10, 10, -1, 20);

    for (int r = 0; r < 8; r++) begin
      lim = int'($urandom_range(0, 20));
      eb  = ($urandom % 2) ? int'($urandom_range(0, 25)) : -1;
      hr  = ($urandom % 3 == 0) ? int'($urandom_range(0, 25)) : -1;
      if (lim == 0 && eb < 0 && hr < 0) eb = 7;
      doRun(lim, eb, hr, 40);
    end

    // Reset in the middle of a load, then a fresh run must count from zero.
    doLoad(10, 1'b1, 0, -1, 2, acc);
    reset            = 1'b1;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = $urandom;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_state", state, 0);
    checkOutput("abort_imem_we", ld_if.imem_we, 0);
    checkOutput("abort_words_loaded", words_loaded, 0);
    checkOutput("abort_halt_cause", halt_cause, 0);
    checkOutput("abort_cycle_count", cycle_count, 0);
    ld_if.load_valid = 1'b0;
    nextCycle();
    doRun(5, -1, -1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
